// File: rtl/bp_me_wormhole_packet_decode_lce_resp.sv
// bp_me_wormhole_packet_decode_lce_resp: reassembles wormhole LCE response flits into cid/cord/payload for the CCE
// Ports: clk_i, reset_n_i (async active-low); link_data_i/link_v_i/link_ready_o flit input;
// payload_o/cid_o/cord_o/v_o/yumi_i packet output; overflow_o pulses per discarded excess flit.
module bp_me_wormhole_packet_decode_lce_resp #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 5,
  parameter int len_width_p = 4,
  parameter int cid_width_p = 2,
  parameter int payload_width_p = 600,
  parameter int max_len_p = (cord_width_p + len_width_p + cid_width_p + payload_width_p + flit_width_p - 1) / flit_width_p - 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [flit_width_p-1:0]    link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_o,
  output logic [payload_width_p-1:0] payload_o,
  output logic [cid_width_p-1:0]     cid_o,
  output logic [cord_width_p-1:0]    cord_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic                       overflow_o
);
  localparam int packet_width_lp = cord_width_p + len_width_p + cid_width_p + payload_width_p;
  localparam int buf_w = (max_len_p + 1) * flit_width_p;
  localparam int idx_w = $clog2(max_len_p + 2);
  localparam logic [idx_w-1:0] max_idx = idx_w'(max_len_p);
  localparam logic [1:0] e_idle = 2'd0, e_recv = 2'd1, e_out = 2'd2;
  logic [1:0] state_r;
  logic [buf_w-1:0] data_r;
  logic [idx_w-1:0] idx_r;
  logic [len_width_p-1:0] rem_r, len;
  logic accept;
  assign link_ready_o = state_r != e_out;
  assign accept = link_v_i & link_ready_o;
  assign len = link_data_i[cord_width_p +: len_width_p];
  assign v_o = state_r == e_out;
  assign cord_o = data_r[0 +: cord_width_p];
  assign cid_o = data_r[cord_width_p + len_width_p +: cid_width_p];
  assign payload_o = data_r[packet_width_lp - payload_width_p +: payload_width_p];
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      data_r <= '0;
      idx_r <= '0;
      rem_r <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (state_r == e_idle && accept) begin
        data_r <= buf_w'(link_data_i);
        rem_r <= len;
        idx_r <= idx_w'(1);
        state_r <= (len == '0) ? e_out : e_recv;
      end else if (state_r == e_recv && accept) begin
        for (int k = 1; k <= max_len_p; k++)
          if (idx_r == idx_w'(k)) data_r[k*flit_width_p +: flit_width_p] <= link_data_i;
        overflow_o <= idx_r > max_idx;
        // saturate so an oversize len can never wrap back onto a live slot
        idx_r <= (&idx_r) ? idx_r : idx_r + idx_w'(1);
        rem_r <= rem_r - len_width_p'(1);
        if (rem_r == len_width_p'(1)) state_r <= e_out;
      end else if (state_r == e_out && yumi_i) begin
        state_r <= e_idle;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (reset_n_i) assert (!(yumi_i && !v_o));
endmodule
